seqdet_ctrl: RTL and testbench

Controller for the team's overlapping serial pattern detector.
- Accepts a run-time pattern configuration: pattern bits, length and match threshold.
- Sequences detection over a gated serial bit stream with an IDLE/RUN/DONE FSM.
- Counts overlapping matches and raises an interrupt when the threshold is reached.
- Sits between the software/config interface and the serial input path; it replaces hard-coded per-pattern Moore detectors.

---
 rtl/seqdet_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_seqdet_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seqdet_ctrl.sv
// Overlapping serial pattern detector controller with run-time pattern,
// length and match threshold, sequenced by an IDLE/RUN/DONE FSM.
//
// Ports:
//   clk, reset                 clock, async active-high reset
//   cfg_valid/cfg_ready        config handshake (ready only in IDLE)
//   cfg_pattern/len/thresh     pattern bits, length (1..PAT_W), threshold
//   cfg_err                    1-cycle pulse when an offered config is rejected
//   start, stop                begin/restart a run, abort to IDLE
//   bit_valid, bit_in          serial bit strobe and data
//   match                      registered 1-cycle pulse per completed match
//   match_count                saturating match count for the current run
//   irq, busy, state_o         DONE level, RUN level, FSM state
module seqdet_ctrl #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    localparam int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [CNT_W-1:0] cfg_thresh,
    output logic             cfg_err,
    input  logic             start,
    input  logic             stop,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             irq,
    output logic             busy,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

    state_t           state_q, state_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LEN_W-1:0] seen_q, seen_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] thr_q, thr_d;
    logic             cfg_ok_q, cfg_ok_d;
    logic             cfg_err_q, cfg_err_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [PAT_W-1:0] nxt_hist;
    logic [LEN_W-1:0] nxt_seen;
    logic [PAT_W-1:0] len_mask;
    logic [CNT_W-1:0] cnt_inc;
    logic             hit;
    logic             len_legal;

    // Shifted history and bit count as they will be after an accepted bit;
    // the match is judged against these post-edge values.
    assign nxt_hist = {hist_q[PAT_W-2:0], bit_in};
    assign nxt_seen = (seen_q == LEN_MAX) ? seen_q : seen_q + LEN_W'(1);
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        len_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    assign hit = (nxt_seen >= len_q) &&
                 ((nxt_hist & len_mask) == (pat_q & len_mask));

    assign len_legal = (cfg_len != '0) && (cfg_len <= LEN_MAX);

    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        seen_d    = seen_q;
        pat_d     = pat_q;
        len_d     = len_q;
        thr_d     = thr_q;
        cfg_ok_d  = cfg_ok_q;
        cfg_err_d = 1'b0;
        match_d   = 1'b0;
        cnt_d     = cnt_q;

        if (cfg_valid && (state_q == IDLE)) begin
            if (len_legal) begin
                pat_d    = cfg_pattern;
                len_d    = cfg_len;
                thr_d    = cfg_thresh;
                cfg_ok_d = 1'b1;
            end else begin
                cfg_err_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (!stop && start && cfg_ok_q) begin
                    state_d = RUN;
                    hist_d  = '0;
                    seen_d  = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    hist_d = '0;
                    seen_d = '0;
                    cnt_d  = '0;
                end else if (bit_valid) begin
                    hist_d = nxt_hist;
                    seen_d = nxt_seen;
                    if (hit) begin
                        match_d = 1'b1;
                        cnt_d   = cnt_inc;
                        if ((thr_q != '0) && (cnt_inc == thr_q)) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d = RUN;
                    hist_d  = '0;
                    seen_d  = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            hist_q    <= '0;
            seen_q    <= '0;
            pat_q     <= '0;
            len_q     <= '0;
            thr_q     <= '0;
            cfg_ok_q  <= 1'b0;
            cfg_err_q <= 1'b0;
            match_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            seen_q    <= seen_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            thr_q     <= thr_d;
            cfg_ok_q  <= cfg_ok_d;
            cfg_err_q <= cfg_err_d;
            match_q   <= match_d;
            cnt_q     <= cnt_d;
        end
    end

    assign cfg_ready   = (state_q == IDLE);
    assign cfg_err     = cfg_err_q;
    assign match       = match_q;
    assign match_count = cnt_q;
    assign irq         = (state_q == DONE);
    assign busy        = (state_q == RUN);
    assign state_o     = state_q;

endmodule

// File: tb/tb_seqdet_ctrl.sv
// Directed testbench for seqdet_ctrl.
// One task per scenario, each with its own inline checks.
module tb_seqdet_ctrl;

    logic       clk;
    logic       reset;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic [7:0] cfg_thresh;
    logic       cfg_err;
    logic       start;
    logic       stop;
    logic       bit_valid;
    logic       bit_in;
    logic       match;
    logic [7:0] match_count;
    logic       irq;
    logic       busy;
    logic [1:0] state_o;

    int checks;
    int errors;

    seqdet_ctrl #(.PAT_W(8), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_thresh (cfg_thresh),
        .cfg_err    (cfg_err),
        .start      (start),
        .stop       (stop),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .match      (match),
        .match_count(match_count),
        .irq        (irq),
        .busy       (busy),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are
    // sampled at that same point, i.e. after the edge has settled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [7:0] p, input logic [3:0] l,
                          input logic [7:0] t);
        cfg_valid   = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_thresh  = t;
        step();
        cfg_valid   = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        step();
        bit_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        checks++;
        if (state_o !== 2'd0 || match !== 1'b0 || match_count !== 8'd0 ||
            irq !== 1'b0 || busy !== 1'b0 || cfg_err !== 1'b0 ||
            cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: st=%0d m=%b cnt=%0d irq=%b busy=%b err=%b rdy=%b, want 0 0 0 0 0 0 1",
                     state_o, match, match_count, irq, busy, cfg_err, cfg_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_cfg_err();
        do_cfg(8'h0A, 4'd0, 8'd0);
        checks++;
        if (cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL cfg_err_len0: got %b want 1", cfg_err);
        end
        step();
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_pulse: got %b want 0", cfg_err);
        end
        do_start();
        checks++;
        if (state_o !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_no_cfg: st=%0d busy=%b want 0 0", state_o, busy);
        end
        do_cfg(8'h0A, 4'd9, 8'd0);
        checks++;
        if (cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL cfg_err_len9: got %b want 1", cfg_err);
        end
        do_start();
        checks++;
        if (state_o !== 2'd0) begin
            errors++;
            $display("FAIL start_bad_cfg: st=%0d want 0", state_o);
        end
    endtask

    task automatic test_basic();
        logic [5:0] stream;
        logic [5:0] exp_m;
        stream = 6'b101010;
        exp_m  = 6'b000101;
        do_cfg(8'h0A, 4'd4, 8'd0);
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL cfg_good: err=%b want 0", cfg_err);
        end
        do_start();
        checks++;
        if (state_o !== 2'd1 || busy !== 1'b1 || cfg_ready !== 1'b0 ||
            match_count !== 8'd0) begin
            errors++;
            $display("FAIL run_entry: st=%0d busy=%b rdy=%b cnt=%0d want 1 1 0 0",
                     state_o, busy, cfg_ready, match_count);
        end
        // Config offered in RUN must be ignored, no error pulse.
        do_cfg(8'h00, 4'd0, 8'd0);
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL cfg_in_run: err=%b want 0", cfg_err);
        end
        for (int i = 5; i >= 0; i--) begin
            send_bit(stream[i]);
            checks++;
            if (match !== exp_m[i]) begin
                errors++;
                $display("FAIL basic_match bit%0d: got %b want %b",
                         5 - i, match, exp_m[i]);
            end
        end
        step();
        checks++;
        if (match !== 1'b0 || match_count !== 8'd2 || state_o !== 2'd1) begin
            errors++;
            $display("FAIL basic_end: m=%b cnt=%0d st=%0d want 0 2 1",
                     match, match_count, state_o);
        end
        do_stop();
        checks++;
        if (state_o !== 2'd0 || match_count !== 8'd2) begin
            errors++;
            $display("FAIL stop_retain: st=%0d cnt=%0d want 0 2",
                     state_o, match_count);
        end
    endtask

    task automatic test_thresh();
        logic [7:0] stream;
        logic [7:0] exp_m;
        stream = 8'b10101010;
        exp_m  = 8'b00010100;
        do_cfg(8'h0A, 4'd4, 8'd2);
        do_start();
        for (int i = 7; i >= 0; i--) begin
            send_bit(stream[i]);
            checks++;
            if (match !== exp_m[i]) begin
                errors++;
                $display("FAIL thresh_match bit%0d: got %b want %b",
                         7 - i, match, exp_m[i]);
            end
            if (i == 2) begin
                checks++;
                if (state_o !== 2'd2 || irq !== 1'b1 || busy !== 1'b0 ||
                    match_count !== 8'd2) begin
                    errors++;
                    $display("FAIL thresh_done: st=%0d irq=%b busy=%b cnt=%0d want 2 1 0 2",
                             state_o, irq, busy, match_count);
                end
            end
        end
        checks++;
        if (state_o !== 2'd2 || irq !== 1'b1 || match_count !== 8'd2) begin
            errors++;
            $display("FAIL thresh_hold: st=%0d irq=%b cnt=%0d want 2 1 2",
                     state_o, irq, match_count);
        end
        do_stop();
        checks++;
        if (state_o !== 2'd0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL done_stop: st=%0d irq=%b want 0 0", state_o, irq);
        end
    endtask

    task automatic test_stop_drop();
        do_cfg(8'h0A, 4'd4, 8'd0);
        do_start();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        stop      = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b0;
        step();
        stop      = 1'b0;
        bit_valid = 1'b0;
        checks++;
        if (state_o !== 2'd0 || match !== 1'b0 || match_count !== 8'd0) begin
            errors++;
            $display("FAIL stop_drop: st=%0d m=%b cnt=%0d want 0 0 0",
                     state_o, match, match_count);
        end
        do_start();
        send_bit(1'b1);
        send_bit(1'b0);
        checks++;
        if (match !== 1'b0 || match_count !== 8'd0 || state_o !== 2'd1) begin
            errors++;
            $display("FAIL hist_cleared: m=%b cnt=%0d st=%0d want 0 0 1",
                     match, match_count, state_o);
        end
        do_stop();
    endtask

    task automatic test_done_ctrl();
        do_cfg(8'h01, 4'd1, 8'd1);
        do_start();
        send_bit(1'b1);
        checks++;
        if (match !== 1'b1 || irq !== 1'b1 || state_o !== 2'd2 ||
            match_count !== 8'd1) begin
            errors++;
            $display("FAIL len1_done: m=%b irq=%b st=%0d cnt=%0d want 1 1 2 1",
                     match, irq, state_o, match_count);
        end
        send_bit(1'b1);
        checks++;
        if (match !== 1'b0 || match_count !== 8'd1) begin
            errors++;
            $display("FAIL done_ignore: m=%b cnt=%0d want 0 1", match, match_count);
        end
        do_start();
        checks++;
        if (state_o !== 2'd1 || irq !== 1'b0 || match_count !== 8'd0) begin
            errors++;
            $display("FAIL done_restart: st=%0d irq=%b cnt=%0d want 1 0 0",
                     state_o, irq, match_count);
        end
        send_bit(1'b1);
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if (state_o !== 2'd0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL done_start_stop: st=%0d irq=%b want 0 0", state_o, irq);
        end
    endtask

    task automatic test_saturate();
        int bad;
        bad = 0;
        do_cfg(8'h01, 4'd1, 8'd0);
        do_start();
        for (int i = 1; i <= 300; i++) begin
            send_bit(1'b1);
            checks++;
            if (match !== 1'b1) begin
                errors++;
                bad++;
                if (bad < 4)
                    $display("FAIL sat_match bit%0d: got %b want 1", i, match);
            end
            if (i == 255 || i == 300) begin
                checks++;
                if (match_count !== 8'd255) begin
                    errors++;
                    $display("FAIL sat_count bit%0d: got %0d want 255",
                             i, match_count);
                end
            end
        end
        checks++;
        if (state_o !== 2'd1) begin
            errors++;
            $display("FAIL sat_state: got %0d want 1", state_o);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        cfg_valid   = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_thresh  = '0;
        start       = 1'b0;
        stop        = 1'b0;
        bit_valid   = 1'b0;
        bit_in      = 1'b0;
        test_reset();
        test_cfg_err();
        test_basic();
        test_thresh();
        test_stop_drop();
        test_done_ctrl();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
